carry_chain_combiner: RTL and testbench
=======================================

Name: carry_chain_combiner

Overview:
- Consumer end of the 34-bit block-adder result bus {p, g, s, t}.
- Takes a stream of per-16-bit-block adder results, least-significant block first, and resolves the inter-block carry serially.
- Emits the final sum word per block, plus the carry-out at the end of each multi-block operand.
- Sits directly downstream of the block adder; lets the design build wide additions from one 16-bit adder over several cycles.

Parameters:
- W, 16, block width in bits; the result bus is 2W+2 bits.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  in_res/in_first/in_last valid
- in_ready  output  1  combiner accepts the input word this cycle
- in_res  input  2W+2  {p, g, s, t}
  - p = bit 2W+1 (block propagate)
  - g = bit 2W (block generate)
  - s = [2W-1:W] (sum with carry-in 1)
  - t = [W-1:0] (sum with carry-in 0)
- in_first  input  1  word is least-significant block of an operand
- in_last  input  1  word is most-significant block of an operand
- cin  input  1  carry-in for the first block; sampled with the in_first word
- out_valid  output  1  out_sum valid
- out_ready  input  1  downstream accepts out_sum
- out_sum  output  W  resolved sum block
- out_last  output  1  out_sum is the final block of the operand
- out_cout  output  1  operand carry-out; meaningful only when out_last=1
- err  output  1  sticky protocol error (PG_CHECK_EN only; else tied 0)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, out_sum=0, out_last=0, out_cout=0, err=0.
  - Carry register=0, FSM in IDLE.
  - Reset mid-operand discards the partial operand; no output is produced for it.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - in_ready = !out_valid | out_ready (single output register, full throughput).
  - in_ready is combinational from out_ready.
  - out_* holds stable while out_valid & !out_ready.
- Latency: 1 cycle from input transfer to out_valid.
- Per accepted word, with c_in = cin if the word starts an operand, else the carry register:
  - out_sum <= c_in ? s : t
  - carry <= g | (p & c_in)
  - out_last <= in_last
  - out_cout <= g | (p & c_in) when in_last, else 0
- FSM:
  - IDLE: any accepted word starts an operand, using cin even if in_first=0. Go to RUN unless in_last=1.
  - RUN:
    - Word with in_first=1 restarts the operand from cin; the previous operand is abandoned.
    - Word with in_last=1 returns to IDLE.
  - A single-block operand has in_first=in_last=1 and stays in IDLE.
- No new arithmetic width growth: out_sum is exactly W bits; the carry register is 1 bit.
- Back-to-back operands: a last word followed in the next cycle by a first word needs no bubble.

Optional Feature:
- Macro: PG_CHECK_EN.
- Defined:
  - An accepted word with p=1 and g=1 (illegal from a block adder) sets err.
  - An in_first word accepted in RUN also sets err.
  - err clears only on reset; data path behaviour is unchanged.
- Undefined: err tied to 0 and no check logic is built.

Decomposition:
- Shared package adder_pkg:
  - Constants: W, RES_W=2W+2, and the bit positions of P, G, S and T.
  - Typedef block_res_t for the packed {p, g, s, t} struct.
  - State enum {IDLE, RUN}.
- One natural sub-module: carry_select_cell (combinational).
  - Inputs: c_in, p, g, s, t.
  - Outputs: sum and c_out.
  - Instantiated once; the top holds the FSM, carry register and output register.

Test Plan:
- Single block: cin=0, first=last=1, p=0, g=0, s=0x1235, t=0x1234 -> out_sum=0x1234, out_last=1, out_cout=0, latency 1.
- Two-block carry ripple, cin=0:
  - Word0: p=0, g=1, s=0xFFFF, t=0xFFFE -> out_sum=0xFFFE.
  - Word1 (last): p=1, g=0, s=0x0000, t=0xFFFF -> out_sum=0x0000, out_cout=1.
- Backpressure: hold out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_sum stable. Release -> next word is accepted the same cycle.
- Restart: in RUN with carry=1, send first=1, cin=0, p=0, g=0, t=0x00AA -> out_sum=0x00AA; with PG_CHECK_EN, err=1.
- Reset mid-operand: after word0 of a 3-block operand, pulse rst_n=0 -> out_valid=0, err=0. Next first word uses cin, not the stale carry.
- Illegal p=g=1 word under PG_CHECK_EN -> err=1, sticky across later clean operands. Without the macro -> err stays 0.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the 16-bit block-adder result bus {p, g, s, t}.
package adder_pkg;

  localparam int W     = 16;
  localparam int RES_W = 2 * W + 2;
  localparam int P_BIT = 2 * W + 1;
  localparam int G_BIT = 2 * W;
  localparam int S_MSB = 2 * W - 1;
  localparam int S_LSB = W;
  localparam int T_MSB = W - 1;
  localparam int T_LSB = 0;

  typedef struct packed {
    logic         p;
    logic         g;
    logic [W-1:0] s;
    logic [W-1:0] t;
  } block_res_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/carry_select_cell.sv
// Picks the precomputed sum for the known carry-in and forms the block carry-out.
module carry_select_cell #(
  parameter int W = 16
) (
  input  logic         c_in,
  input  logic         p,
  input  logic         g,
  input  logic [W-1:0] s,
  input  logic [W-1:0] t,
  output logic [W-1:0] sum,
  output logic         c_out
);

  assign sum   = c_in ? s : t;
  assign c_out = g | (p & c_in);

endmodule

// File: rtl/carry_chain_combiner.sv
// Serially resolves inter-block carries over a least-significant-first stream of block results.
// Optional macro PG_CHECK_EN builds the sticky protocol-error flag on err.
module carry_chain_combiner #(
  parameter int W = adder_pkg::W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W+1:0]   in_res,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum,
  output logic             out_last,
  output logic             out_cout,
  output logic             err
);
  import adder_pkg::*;

  state_t         r_state;
  logic           r_carry;
  logic           r_out_valid;
  logic [W-1:0]   r_out_sum;
  logic           r_out_last;
  logic           r_out_cout;

  logic           w_p;
  logic           w_g;
  logic [W-1:0]   w_s;
  logic [W-1:0]   w_t;
  logic           w_acc;
  logic           w_start;
  logic           w_cin;
  logic [W-1:0]   w_sum;
  logic           w_cout;

  assign w_p = in_res[2*W+1];
  assign w_g = in_res[2*W];
  assign w_s = in_res[2*W-1:W];
  assign w_t = in_res[W-1:0];

  assign in_ready = !r_out_valid | out_ready;
  assign w_acc    = in_valid & in_ready;

  // Outside an operand every word is treated as a start, even without in_first.
  assign w_start = (r_state == IDLE) | in_first;
  assign w_cin   = w_start ? cin : r_carry;

  carry_select_cell #(.W(W)) u_cell (
    .c_in  (w_cin),
    .p     (w_p),
    .g     (w_g),
    .s     (w_s),
    .t     (w_t),
    .sum   (w_sum),
    .c_out (w_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_carry     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_last  <= 1'b0;
      r_out_cout  <= 1'b0;
    end else if (w_acc) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= w_sum;
      r_out_last  <= in_last;
      r_out_cout  <= in_last & w_cout;
      r_carry     <= w_cout;
      r_state     <= in_last ? IDLE : RUN;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_last  = r_out_last;
  assign out_cout  = r_out_cout;

`ifdef PG_CHECK_EN
  logic r_err;

  // p=g=1 cannot come from a real block adder; in_first inside RUN abandons an operand.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_acc && ((w_p && w_g) || (r_state == RUN && in_first))) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_carry_chain_combiner.sv
// Self-checking bench: directed test-plan cases plus random wide additions checked against integer arithmetic.
module tb_carry_chain_combiner;
  import adder_pkg::*;

  typedef struct packed {
    logic [15:0] sum;
    logic        last;
    logic        cout;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [RES_W-1:0] in_res;
  logic             in_first;
  logic             in_last;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_sum;
  logic             out_last;
  logic             out_cout;
  logic             err;

  int   n_checks;
  int   n_errors;
  exp_t q[$];
  bit   ready_rand;
  bit   ready_force;
  logic exp_err;

  carry_chain_combiner #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_res    (in_res),
    .in_first  (in_first),
    .in_last   (in_last),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_cout  (out_cout),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [RES_W-1:0] mk(input logic p, input logic g,
                                          input logic [15:0] s, input logic [15:0] t);
    block_res_t r;
    r.p = p;
    r.g = g;
    r.s = s;
    r.t = t;
    return r;
  endfunction

  // What a real block adder reports for a + b.
  function automatic logic [RES_W-1:0] from_ops(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] x;
    x = {1'b0, a} + {1'b0, b};
    return mk(x[15:0] == 16'hFFFF, x[16], x[15:0] + 16'd1, x[15:0]);
  endfunction

  // Output side: random or forced out_ready, and scoreboard pop on each transfer.
  always @(negedge clk) begin
    out_ready = ready_rand ? ($urandom_range(3) != 0) : ready_force;
    #3;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_sum", 32'(out_sum), 32'(e.sum));
        check("out_last", 32'(out_last), 32'(e.last));
        check("out_cout", 32'(out_cout), 32'(e.cout));
      end
    end
  end

  task automatic drive(input logic [RES_W-1:0] res, input logic f, input logic l,
                       input logic c, input exp_t e);
    bit done;
    done = 0;
    @(negedge clk);
    in_res   = res;
    in_first = f;
    in_last  = l;
    cin      = c;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #3;
      if (in_ready) begin
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        done = 1;
        break;
      end
      @(negedge clk);
    end
    if (!done) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    exp_t        e;
    exp_t        e1;
    exp_t        e2;
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] x;
    logic        carry;
    logic        c0;
    int          n;

    n_checks    = 0;
    n_errors    = 0;
    ready_rand  = 0;
    ready_force = 1;
    exp_err     = 1'b0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_res      = '0;
    in_first    = 1'b0;
    in_last     = 1'b0;
    cin         = 1'b0;
    out_ready   = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_cout", 32'(out_cout), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single block, one-cycle latency
    e = '{sum: 16'h1234, last: 1'b1, cout: 1'b0};
    drive(mk(1'b0, 1'b0, 16'h1235, 16'h1234), 1'b1, 1'b1, 1'b0, e);
    check("latency_valid", 32'(out_valid), 32'd1);
    drain();

    // two-block ripple
    e = '{sum: 16'hFFFE, last: 1'b0, cout: 1'b0};
    drive(mk(1'b0, 1'b1, 16'hFFFF, 16'hFFFE), 1'b1, 1'b0, 1'b0, e);
    e = '{sum: 16'h0000, last: 1'b1, cout: 1'b1};
    drive(mk(1'b1, 1'b0, 16'h0000, 16'hFFFF), 1'b0, 1'b1, 1'b0, e);
    drain();

    // backpressure
    ready_force = 0;
    e1 = '{sum: 16'h0F0F, last: 1'b1, cout: 1'b0};
    drive(mk(1'b0, 1'b0, 16'h0F10, 16'h0F0F), 1'b1, 1'b1, 1'b0, e1);
    @(negedge clk);
    in_res   = mk(1'b0, 1'b0, 16'h0A0B, 16'h0A0A);
    in_first = 1'b1;
    in_last  = 1'b1;
    cin      = 1'b1;
    in_valid = 1'b1;
    e2 = '{sum: 16'h0A0B, last: 1'b1, cout: 1'b0};
    for (int i = 0; i < 3; i++) begin
      #2;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_hold_sum", 32'(out_sum), 32'(e1.sum));
      if (i == 2) ready_force = 1;
      @(negedge clk);
    end
    #3;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    q.push_back(e2);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // restart inside RUN with carry=1
    e = '{sum: 16'h1110, last: 1'b0, cout: 1'b0};
    drive(mk(1'b0, 1'b1, 16'h1111, 16'h1110), 1'b1, 1'b0, 1'b0, e);
    e = '{sum: 16'h00AA, last: 1'b1, cout: 1'b0};
    drive(mk(1'b0, 1'b0, 16'h00AB, 16'h00AA), 1'b1, 1'b1, 1'b0, e);
`ifdef PG_CHECK_EN
    exp_err = 1'b1;
`endif
    drain();
    check("restart_err", 32'(err), 32'(exp_err));

    // reset mid-operand, with the output held and a carry of 1 pending
    ready_force = 0;
    e = '{sum: 16'h2221, last: 1'b0, cout: 1'b0};
    drive(mk(1'b0, 1'b1, 16'h2221, 16'h2220), 1'b1, 1'b0, 1'b1, e);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    exp_err = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ready_force = 1;
    e = '{sum: 16'h0055, last: 1'b1, cout: 1'b0};
    drive(mk(1'b0, 1'b0, 16'h0056, 16'h0055), 1'b0, 1'b1, 1'b0, e);
    drain();

    // illegal p=g=1, then a clean operand
    e = '{sum: 16'h0001, last: 1'b1, cout: 1'b1};
    drive(mk(1'b1, 1'b1, 16'h0001, 16'h0000), 1'b1, 1'b1, 1'b1, e);
`ifdef PG_CHECK_EN
    exp_err = 1'b1;
`endif
    drain();
    check("illegal_err", 32'(err), 32'(exp_err));
    e = '{sum: 16'h0008, last: 1'b1, cout: 1'b0};
    drive(from_ops(16'h0003, 16'h0005), 1'b1, 1'b1, 1'b0, e);
    drain();
    check("sticky_err", 32'(err), 32'(exp_err));

    // random multi-block additions against plain integer arithmetic
    ready_rand = 1;
    for (int op = 0; op < 40; op++) begin
      n     = $urandom_range(4, 1);
      c0    = 1'($urandom_range(1));
      carry = c0;
      for (int k = 0; k < n; k++) begin
        a = 16'($urandom);
        b = ($urandom_range(4) == 0) ? ~a : 16'($urandom);
        x = {1'b0, a} + {1'b0, b} + {16'd0, carry};
        carry  = x[16];
        e.sum  = x[15:0];
        e.last = (k == n - 1);
        e.cout = (k == n - 1) ? carry : 1'b0;
        if ($urandom_range(3) == 0) @(posedge clk);
        drive(from_ops(a, b), k == 0, k == n - 1, (k == 0) ? c0 : 1'($urandom_range(1)), e);
      end
    end
    drain();
    ready_rand = 0;
    check("final_err", 32'(err), 32'(exp_err));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
